// File: rtl/zswitch_array.sv
// zswitch_array: independent per-channel push-button conditioners. Each channel runs a
// 2-flop synchroniser, a debouncer, press/release strobes and long-press/auto-repeat timing.
module zswitch_chan #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 0,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic iClk,
   input  logic iRstN,
   input  logic iSw,
   output logic oSwDown,
   output logic oSwUp,
   output logic oSwLevel,
   output logic oSwLong
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_T  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] REP_T   = HW'(REPEAT_CYCLES);

   logic          pressed;
   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          down_q, down_d, up_q, up_d, long_q, long_d;
   logic          rep_q, rep_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d, hold_inc, target;

   assign pressed = (ACTIVE_LOW != 0) ? ~iSw : iSw;

   always_comb begin
      stable_d = stable_q;
      down_d   = 1'b0;
      up_d     = 1'b0;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            down_d   = sync2_q;
            up_d     = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // After the first long strobe the counter restarts and times the repeat interval;
   // with repeat disabled it simply stops, giving one long strobe per press.
   always_comb begin
      hold_inc = hold_q + 1'b1;
      target   = rep_q ? REP_T : LONG_T;
      hold_d   = hold_q;
      rep_d    = rep_q;
      long_d   = 1'b0;
      if (!stable_q || !stable_d) begin
         hold_d = '0;
         rep_d  = 1'b0;
      end else if (!(rep_q && REPEAT_CYCLES == 0)) begin
         hold_d = hold_inc;
         if (hold_inc == target) begin
            hold_d = '0;
            rep_d  = 1'b1;
            long_d = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         down_q   <= 1'b0;
         up_q     <= 1'b0;
         long_q   <= 1'b0;
         rep_q    <= 1'b0;
         hold_q   <= '0;
      end else begin
         sync1_q  <= pressed;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         down_q   <= down_d;
         up_q     <= up_d;
         long_q   <= long_d;
         rep_q    <= rep_d;
         hold_q   <= hold_d;
      end
   end

   assign oSwDown  = down_q;
   assign oSwUp    = up_q;
   assign oSwLevel = stable_q;
   assign oSwLong  = long_q;
endmodule

module zswitch_array #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 0,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic [CHANNELS-1:0] iSw,
   output logic [CHANNELS-1:0] oSwDown,
   output logic [CHANNELS-1:0] oSwUp,
   output logic [CHANNELS-1:0] oSwLevel,
   output logic [CHANNELS-1:0] oSwLong
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      zswitch_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
         .iClk    (iClk),
         .iRstN   (iRstN),
         .iSw     (iSw[g]),
         .oSwDown (oSwDown[g]),
         .oSwUp   (oSwUp[g]),
         .oSwLevel(oSwLevel[g]),
         .oSwLong (oSwLong[g])
      );
   end
endmodule

// File: tb/tb_zswitch_array.sv
// Bench for zswitch_array: directed scenarios plus random pin activity, compared every
// cycle against a window-based reference model of debounce and press timing.
module tb_zswitch_array;
   localparam int CH = 4, DB = 8, LG = 32, RP = 16, AL = 1;

   logic          iClk = 1'b0;
   logic          iRstN = 1'b0;
   logic [CH-1:0] iSw = '1;
   logic [CH-1:0] oSwDown, oSwUp, oSwLevel, oSwLong;

   zswitch_array #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG),
      .REPEAT_CYCLES(RP), .ACTIVE_LOW(AL)
   ) dut (
      .iClk(iClk), .iRstN(iRstN), .iSw(iSw),
      .oSwDown(oSwDown), .oSwUp(oSwUp), .oSwLevel(oSwLevel), .oSwLong(oSwLong)
   );

   always #5 iClk = ~iClk;

   int n_chk = 0, n_err = 0;
   int n;                      // edges since reset release
   bit sh [CH][8192];          // normalised pin sample taken at each edge
   bit stb [CH];
   int t_dn [CH];
   logic [CH-1:0] e_dn, e_up, e_lv, e_lg;
   int cnt_dn [CH], cnt_up [CH], cnt_lg [CH], at_dn [CH], at_up [CH];
   int hold_left [CH];
   int k, t;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
      end
   endtask

   function automatic bit samp(input int c, input int idx);
      return (idx >= 1) ? sh[c][idx] : 1'b0;
   endfunction

   task automatic model_reset();
      n = 0;
      e_dn = '0; e_up = '0; e_lv = '0; e_lg = '0;
      for (int c = 0; c < CH; c++) begin
         stb[c] = 1'b0;
         t_dn[c] = 0;
         for (int i = 0; i < 8192; i++) sh[c][i] = 1'b0;
      end
   endtask

   task automatic clr_cnt();
      for (int c = 0; c < CH; c++) begin
         cnt_dn[c] = 0; cnt_up[c] = 0; cnt_lg[c] = 0; at_dn[c] = -1; at_up[c] = -1;
      end
   endtask

   // One clock: model the edge, then compare on the falling edge.
   task automatic cyc();
      bit flip;
      int d;
      @(posedge iClk);
      n++;
      for (int c = 0; c < CH; c++) begin
         sh[c][n] = (AL != 0) ? ~iSw[c] : iSw[c];
         // stable changes once DB consecutive synchronised samples disagree with it
         flip = 1'b1;
         for (int j = 0; j < DB; j++)
            if (samp(c, n - 2 - j) == stb[c]) flip = 1'b0;
         e_dn[c] = 1'b0; e_up[c] = 1'b0; e_lg[c] = 1'b0;
         if (flip) begin
            stb[c] = ~stb[c];
            if (stb[c]) begin e_dn[c] = 1'b1; t_dn[c] = n; end
            else e_up[c] = 1'b1;
         end else if (stb[c]) begin
            d = n - t_dn[c];
            e_lg[c] = (d == LG) || (RP > 0 && d > LG && (d - LG) % RP == 0);
         end
         e_lv[c] = stb[c];
      end
      @(negedge iClk);
      chk("down", oSwDown, e_dn);
      chk("up", oSwUp, e_up);
      chk("level", oSwLevel, e_lv);
      chk("long", oSwLong, e_lg);
      for (int c = 0; c < CH; c++) begin
         if (oSwDown[c]) begin cnt_dn[c]++; at_dn[c] = n; end
         if (oSwUp[c]) begin cnt_up[c]++; at_up[c] = n; end
         if (oSwLong[c]) cnt_lg[c]++;
      end
   endtask

   initial begin
      model_reset();
      clr_cnt();
      #12;
      chk("rst_out", {oSwDown, oSwUp, oSwLevel, oSwLong}, 0);
      @(negedge iClk);
      iRstN = 1'b1;

      // clean press on channel 0, pin low before edge 10
      repeat (9) cyc();
      iSw[0] = 1'b0;
      repeat (15) cyc();
      chk("clean_lat", at_dn[0], 19);
      chk("clean_others", cnt_dn[1] + cnt_dn[2] + cnt_dn[3], 0);
      chk("clean_lvl", oSwLevel, 4'b0001);

      // bounce on channel 1
      clr_cnt();
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) iSw[1] = ~iSw[1];
         cyc();
      end
      iSw[1] = 1'b0;
      k = n + 1;
      repeat (20) cyc();
      chk("bounce_dn", cnt_dn[1], 1);
      chk("bounce_up", cnt_up[1], 0);
      chk("bounce_lat", at_dn[1], k + DB + 1);

      // long press and repeat on channel 2
      clr_cnt();
      iSw[2] = 1'b0;
      for (int i = 0; i < 40 && cnt_dn[2] == 0; i++) cyc();
      chk("long_dn", cnt_dn[2], 1);
      t = at_dn[2];
      while (n < t + 80) cyc();
      chk("long_cnt", cnt_lg[2], 4);
      iSw[2] = 1'b1;
      cnt_lg[2] = 0;
      repeat (30) cyc();
      chk("long_after", cnt_lg[2], 0);
      chk("long_up", cnt_up[2], 1);
      chk("long_up_lat", at_up[2], t + 81 + DB + 1);

      // short press on channel 3
      clr_cnt();
      iSw[3] = 1'b0;
      repeat (20) cyc();
      iSw[3] = 1'b1;
      repeat (20) cyc();
      chk("short_dn", cnt_dn[3], 1);
      chk("short_up", cnt_up[3], 1);
      chk("short_long", cnt_lg[3], 0);

      // simultaneous press on channels 0 and 3
      iSw[0] = 1'b1;
      repeat (20) cyc();
      clr_cnt();
      iSw[0] = 1'b0;
      iSw[3] = 1'b0;
      repeat (15) cyc();
      chk("sim_dn0", cnt_dn[0], 1);
      chk("sim_dn3", cnt_dn[3], 1);
      chk("sim_same", at_dn[3] - at_dn[0], 0);

      // asynchronous reset while channels 0 and 3 are held
      repeat (5) cyc();
      #2 iRstN = 1'b0;
      #1 chk("rst_async", {oSwDown, oSwUp, oSwLevel, oSwLong}, 0);
      @(negedge iClk);
      chk("rst_hold", {oSwDown, oSwUp, oSwLevel, oSwLong}, 0);
      @(negedge iClk);
      iRstN = 1'b1;
      model_reset();
      clr_cnt();
      repeat (14) cyc();
      chk("rst_redn0", at_dn[0], DB + 2);
      chk("rst_redn3", at_dn[3], DB + 2);

      // random pin activity: mix of short glitches and long holds
      for (int c = 0; c < CH; c++) hold_left[c] = $urandom_range(1, 60);
      repeat (3000) begin
         for (int c = 0; c < CH; c++) begin
            hold_left[c]--;
            if (hold_left[c] <= 0) begin
               iSw[c] = ~iSw[c];
               hold_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB)
                                                          : $urandom_range(1, 70);
            end
         end
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
